// File: rtl/sa_result_drain.sv
// ---------------------------------------------------------------------------
// SaResultDrain (module sa_result_drain)
//
// Consumer end of the systolic-array result interface. When the array
// strobes I_OUT_VLD the whole SA_R x SA_C result matrix is copied into a
// local buffer. The buffer is then replayed one row per valid/ready transfer
// to the downstream scaling/softmax logic. Because the matrix is held
// locally, the array is free to start its next tile while the previous
// result drains.
//
// Ports
//    I_CLK         clock, rising edge
//    I_ASYN_RSTN   asynchronous active-low reset
//    I_SYNC_RSTN   synchronous active-low clear, same effect as reset
//    I_OUT_VLD     single-cycle strobe, I_OUT_MATRIX holds a finished result
//    I_OUT_MATRIX  result matrix, elem(r,c) = [(r*SA_C+c)*D_W +: D_W]
//    I_ROW_RDY     downstream ready
//    O_ROW_VLD     row outputs valid
//    O_ROW_DATA    current row, elem c = [c*D_W +: D_W]
//    O_ROW_IDX     index of current row
//    O_ROW_LAST    current row is the last row
//    O_ROW_MAX     signed maximum over the elements of the current row
//    O_BUSY        matrix held, drain in progress
//    O_DONE        one-cycle pulse after the last row was accepted
//    O_DROP        one-cycle pulse, a strobe arrived while busy and was ignored
// ---------------------------------------------------------------------------
module sa_result_drain #(
   parameter int D_W  = 16,
   parameter int SA_R = 16,
   parameter int SA_C = 16
) (
   input  logic                       I_CLK,
   input  logic                       I_ASYN_RSTN,
   input  logic                       I_SYNC_RSTN,
   input  logic                       I_OUT_VLD,
   input  logic [SA_R*SA_C*D_W-1:0]   I_OUT_MATRIX,
   input  logic                       I_ROW_RDY,
   output logic                       O_ROW_VLD,
   output logic [SA_C*D_W-1:0]        O_ROW_DATA,
   output logic [$clog2(SA_R)-1:0]    O_ROW_IDX,
   output logic                       O_ROW_LAST,
   output logic [D_W-1:0]             O_ROW_MAX,
   output logic                       O_BUSY,
   output logic                       O_DONE,
   output logic                       O_DROP
);

   localparam int IDX_W = $clog2(SA_R);
   localparam int ROW_W = SA_C * D_W;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   state_t                   state;
   state_t                   state_nxt;
   logic [IDX_W-1:0]         row_idx;
   logic [IDX_W-1:0]         idx_nxt;
   logic                     done_q;
   logic                     done_nxt;
   logic                     drop_q;
   logic                     drop_nxt;
   logic                     capture;
   logic                     handshake;
   logic                     last_row;
   logic                     row_vld;
   logic [SA_R*SA_C*D_W-1:0] mat_buf;
   logic [ROW_W-1:0]         rows [SA_R];
   logic [ROW_W-1:0]         cur_row;
   logic [D_W-1:0]           row_max;

   assign row_vld   = (state == SEND);
   assign handshake = row_vld && I_ROW_RDY;
   assign last_row  = (row_idx == IDX_W'(SA_R - 1));

   // State, row counter and the two status pulses. The synchronous clear is
   // folded into the next-state logic so this block only knows the async reset.
   always_ff @(posedge I_CLK or negedge I_ASYN_RSTN) begin
      if (!I_ASYN_RSTN) begin
         state   <= IDLE;
         row_idx <= '0;
         done_q  <= 1'b0;
         drop_q  <= 1'b0;
      end else begin
         state   <= state_nxt;
         row_idx <= idx_nxt;
         done_q  <= done_nxt;
         drop_q  <= drop_nxt;
      end
   end

   // The matrix buffer has no reset: its contents only matter after a
   // capture, and leaving it out of reset keeps the wide register cheap.
   always_ff @(posedge I_CLK) begin
      if (capture) begin
         mat_buf <= I_OUT_MATRIX;
      end
   end

   // Next-state logic. A strobe is accepted only from IDLE or in the very
   // cycle the last row is handed off, which lets back-to-back tiles stream
   // with no valid gap. Any other strobe while draining is dropped and
   // flagged. A low synchronous clear beats everything, including a strobe.
   always_comb begin
      state_nxt = state;
      idx_nxt   = row_idx;
      done_nxt  = 1'b0;
      drop_nxt  = 1'b0;
      capture   = 1'b0;
      if (!I_SYNC_RSTN) begin
         state_nxt = IDLE;
         idx_nxt   = '0;
      end else begin
         case (state)
            IDLE: begin
               if (I_OUT_VLD) begin
                  capture   = 1'b1;
                  state_nxt = SEND;
                  idx_nxt   = '0;
               end
            end
            SEND: begin
               if (handshake && last_row) begin
                  done_nxt = 1'b1;
                  idx_nxt  = '0;
                  if (I_OUT_VLD) begin
                     capture = 1'b1;
                  end else begin
                     state_nxt = IDLE;
                  end
               end else begin
                  if (handshake) begin
                     idx_nxt = row_idx + IDX_W'(1);
                  end
                  if (I_OUT_VLD) begin
                     drop_nxt = 1'b1;
                  end
               end
            end
            default: begin
               state_nxt = IDLE;
               idx_nxt   = '0;
            end
         endcase
      end
   end

   // Split the flat buffer into rows so the current row is a plain index.
   always_comb begin
      for (int r = 0; r < SA_R; r++) begin
         rows[r] = mat_buf[r*ROW_W +: ROW_W];
      end
   end

   assign cur_row = rows[row_idx];

   // Signed maximum of the current row as a balanced compare tree, laid out
   // heap-style: leaves at SA_C-1 .. 2*SA_C-2, node i takes the larger of
   // its children 2i+1 and 2i+2. This works for any SA_C, not only powers
   // of two, and keeps the depth logarithmic.
   always_comb begin : max_tree
      logic signed [D_W-1:0] node [2*SA_C-1];
      for (int c = 0; c < SA_C; c++) begin
         node[SA_C-1+c] = cur_row[c*D_W +: D_W];
      end
      for (int i = SA_C - 2; i >= 0; i--) begin
         node[i] = (node[2*i+1] > node[2*i+2]) ? node[2*i+1] : node[2*i+2];
      end
      row_max = node[0];
   end

   // Row outputs are forced to zero when nothing is being sent so that the
   // undefined buffer never leaks out after reset.
   assign O_ROW_VLD  = row_vld;
   assign O_BUSY     = row_vld;
   assign O_ROW_DATA = row_vld ? cur_row : '0;
   assign O_ROW_IDX  = row_vld ? row_idx : '0;
   assign O_ROW_LAST = row_vld && last_row;
   assign O_ROW_MAX  = row_vld ? row_max : '0;
   assign O_DONE     = done_q;
   assign O_DROP     = drop_q;

endmodule
